// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Optional: define MULT_DIV_EARLY_OUT_EN to end a multiply once the remaining multiplier bits are 0.
module mult_div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {StIdle, StMul, StDiv, StFix, StDone} state_e;

    state_e             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               is_div_q, is_div_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               is_signed;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     part, diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_step;
    logic               mul_last;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    // Datapath helpers: operand magnitudes, one restoring-division step, sign fix-up.
    always_comb begin
        is_signed = (Op == 3'b000) || (Op == 3'b010);
        abs_a     = (is_signed && A[WIDTH-1]) ? -A : A;
        abs_b     = (is_signed && B[WIDTH-1]) ? -B : B;
        part      = acc_q[2*WIDTH-1:WIDTH-1];
        diff      = part - {1'b0, mcand_q[WIDTH-1:0]};
        q_bit     = (part >= {1'b0, mcand_q[WIDTH-1:0]});
        rem_step  = q_bit ? diff[WIDTH-1:0] : part[WIDTH-1:0];
`ifdef MULT_DIV_EARLY_OUT_EN
        mul_last  = (cnt_q == CntW'(1)) || ((mplier_q >> 1) == '0);
`else
        mul_last  = (cnt_q == CntW'(1));
`endif
        prod_fix  = neg_q ? -acc_q : acc_q;
        quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix   = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        is_div_d = is_div_q;
        dbz_d    = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;

        case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (Start && !Flush) begin
                    case (Op)
                        3'b000, 3'b001, 3'b010, 3'b011: begin
                            if (Op[1] && (B == '0)) begin
                                state_d = StDone;
                                hi_d    = A;
                                lo_d    = '1;
                                dbz_d   = 1'b1;
                            end else begin
                                state_d  = Op[1] ? StDiv : StMul;
                                is_div_d = Op[1];
                                neg_d    = is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                                rneg_d   = is_signed && A[WIDTH-1];
                                cnt_d    = CntW'(WIDTH);
                                mplier_d = abs_b;
                                mcand_d  = {{WIDTH{1'b0}}, Op[1] ? abs_b : abs_a};
                                // Divide keeps the dividend in the low half and shifts it up.
                                acc_d    = Op[1] ? {{WIDTH{1'b0}}, abs_a} : '0;
                            end
                        end
                        3'b100:  hi_d = A;
                        3'b101:  lo_d = A;
                        default: ;
                    endcase
                end
            end
            StMul: begin
                if (Flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - CntW'(1);
                    if (mul_last) state_d = StFix;
                end
            end
            StDiv: begin
                if (Flush) begin
                    state_d = StIdle;
                end else begin
                    acc_d = {rem_step, acc_q[WIDTH-2:0], q_bit};
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) state_d = StFix;
                end
            end
            StFix: begin
                if (Flush) begin
                    state_d = StIdle;
                end else begin
                    state_d = StDone;
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= StIdle;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            is_div_q <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            is_div_q <= is_div_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign Busy      = (state_q == StMul) || (state_q == StDiv) || (state_q == StFix);
    assign Done      = (state_q == StDone);
    assign DivByZero = dbz_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;

endmodule
